// File: rtl/parametrik_denetim_birimi.sv
// -----------------------------------------------------------------------------
// parametrik_denetim_birimi
//   Hazard/control unit for the GETIR -> COZ -> YURUT pipeline.
//   - Forwarding select for KAYNAK_SAYISI source operands against ILERI_ASAMA
//     producing stages (stage 0 = YURUT, youngest; higher index = older).
//   - Load-use stall: COZ/GETIR hold while the selected producer's result is
//     not yet available, and a bubble is pushed into YURUT.
//   - Misprediction flush. If it arrives while GETIR is not ready, the flush
//     is remembered until GETIR's next ready cycle.
//   - Startup stall of BASLANGIC_CEVRIM cycles (BASLAT) for cache valid-bit
//     clearing, then CALIS until reset.
//   - Saturating counter of hazard-stall cycles.
// Ports
//   clk_i, rst_ni                         clock, async active-low reset
//   gtr_yanlis_tahmin_i, gtr_hazir_i      misprediction, GETIR valid
//   gtr_durdur_o, gtr_bosalt_o            GETIR hold / flush
//   cyo_rs_adres_i, cyo_rs_gecerli_i      COZ source addresses / read-enables
//   cyo_yonlendir_kontrol_o               per-source select: 0 none, i+1 stage i
//   cyo_durdur_o, cyo_bosalt_o            COZ hold / flush
//   ileri_yaz_yazmac_i, ileri_rd_adres_i  producer write-enable / rd address
//   ileri_veri_hazir_i                    producer result available
//   yrt_hazir_i                           YURUT done (multi-cycle ops)
//   yrt_durdur_o, yrt_bosalt_o            YURUT hold / bubble
//   durum_o                               0 BASLAT, 1 CALIS
//   durma_sayac_o                         hazard-stall cycles, saturating
// -----------------------------------------------------------------------------
module parametrik_denetim_birimi #(
  parameter int ADRES_BIT        = 5,
  parameter int KAYNAK_SAYISI    = 2,
  parameter int ILERI_ASAMA      = 2,
  parameter int BASLANGIC_CEVRIM = 256,
  parameter int SAYAC_BIT        = 16,
  localparam int SEC_BIT         = $clog2(ILERI_ASAMA + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               gtr_yanlis_tahmin_i,
  input  logic                               gtr_hazir_i,
  output logic                               gtr_durdur_o,
  output logic                               gtr_bosalt_o,
  input  logic [KAYNAK_SAYISI*ADRES_BIT-1:0] cyo_rs_adres_i,
  input  logic [KAYNAK_SAYISI-1:0]           cyo_rs_gecerli_i,
  output logic [KAYNAK_SAYISI*SEC_BIT-1:0]   cyo_yonlendir_kontrol_o,
  output logic                               cyo_durdur_o,
  output logic                               cyo_bosalt_o,
  input  logic [ILERI_ASAMA-1:0]             ileri_yaz_yazmac_i,
  input  logic [ILERI_ASAMA*ADRES_BIT-1:0]   ileri_rd_adres_i,
  input  logic [ILERI_ASAMA-1:0]             ileri_veri_hazir_i,
  input  logic                               yrt_hazir_i,
  output logic                               yrt_durdur_o,
  output logic                               yrt_bosalt_o,
  output logic                               durum_o,
  output logic [SAYAC_BIT-1:0]               durma_sayac_o
);

  localparam int                BS_BIT = (BASLANGIC_CEVRIM > 2) ? $clog2(BASLANGIC_CEVRIM) : 1;
  localparam logic [BS_BIT-1:0] BS_SON = BS_BIT'(BASLANGIC_CEVRIM - 1);

  typedef enum logic {
    BASLAT = 1'b0,
    CALIS  = 1'b1
  } durum_t;

  durum_t                             durum_q, durum_d;
  logic [BS_BIT-1:0]                  sayac_q;
  logic                               bekleyen_bosalt_q;
  logic [SAYAC_BIT-1:0]               durma_sayac_q;

  logic [KAYNAK_SAYISI*SEC_BIT-1:0]   yonlendir;
  logic [SEC_BIT-1:0]                 sec;
  logic                               sec_hazir;
  logic                               tehlike;
  logic                               baslat;
  logic                               bosalt;
  logic                               tehlike_etkin;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q           <= BASLAT;
      sayac_q           <= '0;
      bekleyen_bosalt_q <= 1'b0;
      durma_sayac_q     <= '0;
    end else begin
      durum_q <= durum_d;
      if (durum_q == BASLAT && sayac_q != BS_SON) begin
        sayac_q <= sayac_q + 1'b1;
      end
      // Remembered flush is only meaningful once running; during BASLAT the
      // pipeline is flushed unconditionally anyway.
      if (durum_q == CALIS) begin
        if (gtr_hazir_i) begin
          bekleyen_bosalt_q <= 1'b0;
        end else if (gtr_yanlis_tahmin_i) begin
          bekleyen_bosalt_q <= 1'b1;
        end
      end
      if (durum_q == CALIS && tehlike_etkin && durma_sayac_q != '1) begin
        durma_sayac_q <= durma_sayac_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    durum_d = durum_q;
    if (durum_q == BASLAT && sayac_q == BS_SON) begin
      durum_d = CALIS;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding select and load-use detection.
  // Scanning from the oldest stage down lets the youngest match overwrite, so
  // the most recent producer wins even if its data is not ready yet; older
  // copies of the same register are stale.
  // ---------------------------------------------------------------------------
  always_comb begin
    yonlendir = '0;
    tehlike   = 1'b0;
    sec       = '0;
    sec_hazir = 1'b1;
    for (int k = 0; k < KAYNAK_SAYISI; k++) begin
      sec       = '0;
      sec_hazir = 1'b1;
      for (int i = ILERI_ASAMA - 1; i >= 0; i--) begin
        if (cyo_rs_gecerli_i[k] && ileri_yaz_yazmac_i[i] &&
            cyo_rs_adres_i[k*ADRES_BIT +: ADRES_BIT] == ileri_rd_adres_i[i*ADRES_BIT +: ADRES_BIT] &&
            cyo_rs_adres_i[k*ADRES_BIT +: ADRES_BIT] != '0) begin
          sec       = SEC_BIT'(i + 1);
          sec_hazir = ileri_veri_hazir_i[i];
        end
      end
      yonlendir[k*SEC_BIT +: SEC_BIT] = sec;
      if (!sec_hazir) begin
        tehlike = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. BASLAT forces every hold/flush; a flushed COZ instruction cannot
  // raise a stall. yrt_durdur_o follows GETIR because both share one memory
  // port.
  // ---------------------------------------------------------------------------
  always_comb begin
    baslat        = (durum_q == BASLAT);
    bosalt        = baslat | gtr_yanlis_tahmin_i | bekleyen_bosalt_q;
    tehlike_etkin = tehlike & ~bosalt;

    gtr_bosalt_o            = bosalt;
    cyo_bosalt_o            = bosalt;
    gtr_durdur_o            = baslat | ~gtr_hazir_i | ~yrt_hazir_i | tehlike_etkin;
    cyo_durdur_o            = baslat | ~gtr_hazir_i | ~yrt_hazir_i | tehlike_etkin;
    yrt_durdur_o            = baslat | ~gtr_hazir_i;
    yrt_bosalt_o            = ~baslat & tehlike_etkin & gtr_hazir_i & yrt_hazir_i;
    cyo_yonlendir_kontrol_o = baslat ? '0 : yonlendir;
    durum_o                 = ~baslat;
    durma_sayac_o           = durma_sayac_q;
  end

endmodule
